// File: rtl/gl8_pixel_reduce.sv
// N-way luma lane reducer: joins N_CH lanes into one averaged, max, min or
// passthrough pixel behind a 2-entry skid buffer, and flags misaligned markers.
module gl8_pixel_reduce #(
    parameter int D_WIDTH = 8,
    parameter int N_CH    = 4,
    parameter int ROUND   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH*D_WIDTH-1:0]   up_data,
    input  logic [N_CH-1:0]           up_valid,
    input  logic [N_CH-1:0]           up_tlast,
    input  logic [N_CH-1:0]           up_tuser,
    output logic [N_CH-1:0]           up_ready,
    input  logic [1:0]                mode,
    output logic [D_WIDTH-1:0]        down_data,
    output logic                      down_valid,
    output logic                      down_tlast,
    output logic                      down_tuser,
    input  logic                      down_ready,
    output logic                      err_misalign,
    input  logic                      err_clear,
    output logic [15:0]               beat_cnt
);

    localparam int L  = $clog2(N_CH);
    localparam int SW = D_WIDTH + L;

    localparam logic [1:0] MODE_AVG = 2'b00;
    localparam logic [1:0] MODE_MAX = 2'b01;
    localparam logic [1:0] MODE_MIN = 2'b10;

    logic               main_valid;
    logic [D_WIDTH-1:0] main_data;
    logic               main_tlast;
    logic               main_tuser;
    logic               skid_valid;
    logic [D_WIDTH-1:0] skid_data;
    logic               skid_tlast;
    logic               skid_tuser;
    logic               err_q;
    logic [15:0]        cnt_q;

    logic               buf_full;
    logic               accept;
    logic               xfer;
    logic [SW-1:0]      sum;
    logic [SW-1:0]      sum_rnd;
    logic [D_WIDTH-1:0] lane;
    logic [D_WIDTH-1:0] max_v;
    logic [D_WIDTH-1:0] min_v;
    logic [D_WIDTH-1:0] red;
    logic               new_tlast;
    logic               new_tuser;
    logic               misalign;

    // ready depends only on stored occupancy, never on down_ready
    assign buf_full = main_valid & skid_valid;
    assign up_ready = {N_CH{~buf_full}};
    assign accept   = (&up_valid) & ~buf_full;
    assign xfer     = main_valid & down_ready;

    always_comb begin
        sum   = '0;
        max_v = '0;
        min_v = '1;
        lane  = '0;
        for (int i = 0; i < N_CH; i++) begin
            lane = up_data[i*D_WIDTH +: D_WIDTH];
            sum  = sum + SW'(lane);
            if (lane > max_v) max_v = lane;
            if (lane < min_v) min_v = lane;
        end
    end

    // the rounding bias cannot overflow SW bits: N*(2^D-1) + N/2 < N*2^D
    assign sum_rnd = sum + ((ROUND != 0) ? SW'(N_CH / 2) : '0);

    always_comb begin
        case (mode)
            MODE_AVG: red = sum_rnd[SW-1:L];
            MODE_MAX: red = max_v;
            MODE_MIN: red = min_v;
            default:  red = up_data[D_WIDTH-1:0];
        endcase
    end

    assign new_tlast = |up_tlast;
    assign new_tuser = |up_tuser;
    assign misalign  = ~((&up_tlast) | ~(|up_tlast))
                     | ~((&up_tuser) | ~(|up_tuser));

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_tlast <= 1'b0;
            main_tuser <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_tlast <= 1'b0;
            skid_tuser <= 1'b0;
        end else if (xfer) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_tlast <= skid_tlast;
                main_tuser <= skid_tuser;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= red;
                main_tlast <= new_tlast;
                main_tuser <= new_tuser;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_valid <= 1'b1;
                main_data  <= red;
                main_tlast <= new_tlast;
                main_tuser <= new_tuser;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= red;
                skid_tlast <= new_tlast;
                skid_tuser <= new_tuser;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && misalign) begin
            err_q <= 1'b1;
        end else if (err_clear) begin
            err_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= main_tuser ? 16'd1 : cnt_q + 16'd1;
        end
    end

    assign down_valid   = main_valid;
    assign down_data    = main_data;
    assign down_tlast   = main_tlast;
    assign down_tuser   = main_tuser;
    assign err_misalign = err_q;
    assign beat_cnt     = cnt_q;

endmodule

// File: doc/gl8_pixel_reduce.md
# gl8_pixel_reduce

Parametrised N-way pixel reducer for the downscaler datapath. It joins N_CH upstream AXI-Stream-style luma lanes into one reduced pixel. The reduction is a rounded average, max or min, selected per beat. A registered 2-entry skid buffer sits on the output, and the block flags lanes whose tlast/tuser markers disagree. It sits between the line/column splitter lanes and the downstream pixel sink.

## Interface
Parameters:
- D_WIDTH, 8: luma bits per lane.
- N_CH, 4: number of input lanes. Power of two, 2..16. L = log2(N_CH).
- ROUND, 1: in average mode, 1 adds N_CH/2 before the shift (round half up); 0 truncates.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- up_data  in  N_CH*D_WIDTH  lane i occupies bits [i*D_WIDTH +: D_WIDTH].
- up_valid  in  N_CH  per-lane valid.
- up_tlast  in  N_CH  per-lane end-of-line.
- up_tuser  in  N_CH  per-lane start-of-frame.
- up_ready  out  N_CH  per-lane ready; all bits are identical.
- mode  in  2  reduction select: 00 average, 01 max, 10 min, 11 lane-0 passthrough.
- down_data  out  D_WIDTH  reduced pixel.
- down_valid  out  1  output valid.
- down_tlast  out  1  OR of lane tlast for the beat.
- down_tuser  out  1  OR of lane tuser for the beat.
- down_ready  in  1  downstream ready.
- err_misalign  out  1  sticky marker-mismatch flag.
- err_clear  in  1  clears err_misalign.
- beat_cnt  out  16  count of output beats transferred since reset or the last tuser beat.

## Operation
- Join: a beat is accepted when all up_valid bits are 1 and the skid buffer is not full. All lanes are consumed in the same cycle. A lane is never consumed alone.
- up_ready is driven as all-ones when the buffer is not full, regardless of up_valid. A lane holding valid while others are low is not consumed; the source must hold its data.
- Reduction is computed on the accept cycle using the mode value sampled in that cycle.
- Average: sum is D_WIDTH+L bits wide. Result = (sum + (ROUND ? N_CH/2 : 0)) >> L. No overflow is possible.
- Max/min: unsigned compare across all lanes.
- Passthrough: lane 0 data; the other lanes are still consumed.
- Markers: down_tlast and down_tuser are the OR across lanes.
- Misalignment: if an accepted beat has tlast bits not all equal, or tuser bits not all equal, err_misalign is set on the next cycle. It stays set until err_clear.
- If set and clear occur in the same cycle, set wins.
- Skid buffer has two entries: main (drives down_*) and skid.
  - On accept: the beat goes to main if main is empty or main is transferring this cycle with skid empty. Otherwise it goes to skid.
  - When main transfers and skid is full, skid moves to main.
  - Output order always matches accept order.
- beat_cnt increments on each output transfer (down_valid & down_ready). A transferred beat with down_tuser=1 loads beat_cnt to 1. beat_cnt wraps from 0xFFFF to 0.

## Timing
- Latency: 1 cycle from accept to down_valid=1 when the buffer was empty.
- Throughput: 1 beat per cycle while down_ready=1.
- up_ready is a registered function of buffer occupancy, with no combinational path from down_ready. It deasserts the cycle after the buffer becomes full (main full, skid full).
- down_valid must not drop while down_ready=0. down_data, down_tlast and down_tuser are stable while stalled.
- Reset (synchronous, rst=1 at a clk edge):
  - down_valid=0, down_data=0, down_tlast=0, down_tuser=0, up_ready=all-ones.
  - err_misalign=0, beat_cnt=0.
  - Buffer is emptied; in-flight beats are discarded.
  - rst takes priority over all other inputs.
- Stall boundary: with down_ready=0 and continuous input, exactly 2 beats are accepted and then up_ready=0. When down_ready returns to 1, one beat transfers per cycle and up_ready reasserts the cycle after the skid entry drains.
- Simultaneous accept and transfer with buffer full is impossible because up_ready=0. Simultaneous accept and transfer with main only full keeps occupancy at 1.

## Test plan
- Average, D_WIDTH=8, N_CH=4, ROUND=1, down_ready=1:
  - lanes 10,11,11,11 -> down_data 11 one cycle later.
  - With ROUND=0 -> 10.
  - Lanes all 255 -> 255.
- Mode sweep: lanes 3,200,17,90.
  - mode 01 -> 200; mode 10 -> 3; mode 11 -> 3.
  - Mode changed every cycle; each output matches the mode sampled at its accept cycle.
- Partial valid: lanes 0-2 valid, lane 3 valid asserted 5 cycles later -> no output until lane 3 is valid, then a single beat. Exactly one transfer is seen per lane.
- Backpressure: hold down_ready=0 for 6 cycles with continuous input.
  - 2 beats are accepted and up_ready=0 from cycle 3.
  - On release, beats emerge in order with no loss or duplication.
  - down_data stays stable while stalled.
- Markers: tuser=1 on lanes 0-3 -> down_tuser=1 and beat_cnt=1 after transfer, err_misalign=0. tlast=1 on lane 2 only -> down_tlast=1 and err_misalign=1. err_clear -> 0.
- Reset mid-operation: assert rst with the buffer full and err_misalign=1 -> next cycle all outputs at reset values and up_ready all-ones. The first post-reset beat emerges with 1-cycle latency.
